state_run_gen: RTL and testbench

Sequencer that drives the `run` advance input of the main train/inference state machine and launches the per-stage compute blocks. It watches the main state `q`, issues a one-cycle start pulse to the compute block for the current stage, and waits for that block's done. It then pulses `run` so the main state machine advances. The block sits beside the main state machine in the train top level: the main machine holds the state, and this block decides when it moves.

---
 rtl/state_run_gen.sv | 154 +++++++++++++++
 tb/tb_state_run_gen.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_run_gen.sv
// state_run_gen: sequencer that walks the main train/inference state machine.
// It launches the compute block for the stage shown on q, waits for that
// block's done, then pulses run so the main machine advances to the next stage.

module state_run_gen #(
    parameter int unsigned CYC_W     = 24,
    parameter int unsigned ITER_W    = 16,
    parameter int unsigned TIMEOUT   = 1048576,
    parameter int unsigned STATE_LEN = 3,
    parameter int unsigned MODE_LEN  = 1,
    // Main-state and mode encodings shared with the main state machine.
    parameter logic [STATE_LEN-1:0] M_IDLE   = STATE_LEN'(0),
    parameter logic [STATE_LEN-1:0] M_S1     = STATE_LEN'(1),
    parameter logic [STATE_LEN-1:0] M_S2     = STATE_LEN'(2),
    parameter logic [STATE_LEN-1:0] M_S3     = STATE_LEN'(3),
    parameter logic [STATE_LEN-1:0] M_UPDATE = STATE_LEN'(4),
    parameter logic [STATE_LEN-1:0] M_FIN    = STATE_LEN'(5),
    parameter logic [MODE_LEN-1:0]  TRAIN    = MODE_LEN'(1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [MODE_LEN-1:0]  mode,
    input  logic [STATE_LEN-1:0] q,
    input  logic [3:0]           stage_done,
    output logic                 run,
    output logic [3:0]           stage_start,
    output logic                 busy,
    output logic                 fin,
    output logic                 err,
    output logic [ITER_W-1:0]    iter_cnt,
    output logic [CYC_W-1:0]     last_cycles
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StAdv,
        StHalt
    } st_e;

    st_e              state_q;
    logic [3:0]       stage_q;    // one-hot of the stage currently being waited on
    logic [CYC_W-1:0] cnt_q;      // cycles elapsed since stage_start, launch cycle counted

    logic [3:0]       stage_dec;
    logic [CYC_W-1:0] cnt_inc;
    logic             done_hit;
    logic             timeout_hit;

    // Decode q into a stage one-hot and derive the wait-state helpers.
    always_comb begin
        stage_dec = 4'b0000;
        case (q)
            M_S1:     stage_dec = 4'b0001;
            M_S2:     stage_dec = 4'b0010;
            M_S3:     stage_dec = 4'b0100;
            M_UPDATE: stage_dec = 4'b1000;
            default:  stage_dec = 4'b0000;
        endcase

        // Saturating increment; also the done-cycle-inclusive stage duration.
        cnt_inc     = (cnt_q == {CYC_W{1'b1}}) ? cnt_q : cnt_q + CYC_W'(1);
        done_hit    = |(stage_done & stage_q);
        timeout_hit = (32'(cnt_inc) >= TIMEOUT);
    end

    // The launch pulse must appear in the very cycle LAUNCH sees the freshly
    // advanced q, so it is a Moore decode of the state register and q rather
    // than a flop of its own; both sources are registers, so it is glitch-safe.
    assign stage_start = (state_q == StLaunch) ? stage_dec : 4'b0000;

    assign fin = (q == M_FIN);

    // Sequencer FSM with all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            stage_q     <= 4'b0000;
            cnt_q       <= '0;
            run         <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            iter_cnt    <= '0;
            last_cycles <= '0;
        end else begin
            run <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && (q == M_IDLE)) begin
                        state_q <= StAdv;
                        run     <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                StLaunch: begin
                    if (stage_dec != 4'b0000) begin
                        stage_q <= stage_dec;
                        cnt_q   <= CYC_W'(1);
                        state_q <= StWait;
                    end else if ((q == M_FIN) && (mode == TRAIN)) begin
                        state_q <= StAdv;
                        run     <= 1'b1;
                    end else if (q == M_FIN) begin
                        // Inference ends parked on M_FIN.
                        state_q <= StHalt;
                        busy    <= 1'b0;
                    end else begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StHalt;
                    end
                end

                StWait: begin
                    // Done takes priority over a timeout in the same cycle.
                    if (done_hit) begin
                        last_cycles <= cnt_inc;
                        state_q     <= StAdv;
                        run         <= 1'b1;
                    end else if (timeout_hit) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StHalt;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end

                StAdv: begin
                    // q still holds the pre-advance state during this cycle.
                    if (q == M_FIN) begin
                        iter_cnt <= iter_cnt + ITER_W'(1);
                        busy     <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        state_q <= StLaunch;
                    end
                end

                StHalt: begin
                    state_q <= StHalt;
                end

                default: begin
                    state_q <= StHalt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_run_gen.sv
// tb_state_run_gen: directed bench for state_run_gen with a behavioural main
// state machine and a stage-block responder with per-stage done latency.

module tb_state_run_gen;

    localparam int unsigned CYC_W   = 24;
    localparam int unsigned ITER_W  = 2;
    localparam int unsigned TIMEOUT = 16;

    localparam logic [2:0] M_IDLE   = 3'd0;
    localparam logic [2:0] M_S1     = 3'd1;
    localparam logic [2:0] M_S2     = 3'd2;
    localparam logic [2:0] M_S3     = 3'd3;
    localparam logic [2:0] M_UPDATE = 3'd4;
    localparam logic [2:0] M_FIN    = 3'd5;
    localparam logic [0:0] TRAIN    = 1'b1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [0:0]        mode = TRAIN;
    logic [2:0]        q;
    logic [3:0]        stage_done;
    logic [3:0]        resp_done;
    logic [3:0]        force_done = 4'b0000;
    logic              run;
    logic [3:0]        stage_start;
    logic              busy;
    logic              fin;
    logic              err;
    logic [ITER_W-1:0] iter_cnt;
    logic [CYC_W-1:0]  last_cycles;

    int n_vec = 0;
    int n_err = 0;

    int run_cnt = 0;
    int ss_cnt  = 0;
    int bad_cnt = 0;
    logic [15:0] ss_seq = 16'h0000;

    int lat [4] = '{5, 5, 5, 5};
    int resp_wait;
    logic [3:0] resp_bit;

    int r0;
    int s0;
    int exp_iter [4] = '{1, 2, 3, 0};

    assign stage_done = resp_done | force_done;

    always #5 clk = ~clk;

    state_run_gen #(
        .CYC_W   (CYC_W),
        .ITER_W  (ITER_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .q           (q),
        .stage_done  (stage_done),
        .run         (run),
        .stage_start (stage_start),
        .busy        (busy),
        .fin         (fin),
        .err         (err),
        .iter_cnt    (iter_cnt),
        .last_cycles (last_cycles)
    );

    // Main train/inference state machine: advances on run.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= M_IDLE;
        end else if (run) begin
            case (q)
                M_IDLE:   q <= M_S1;
                M_S1:     q <= (mode == TRAIN) ? M_S2 : M_FIN;
                M_S2:     q <= M_S3;
                M_S3:     q <= M_UPDATE;
                M_UPDATE: q <= M_FIN;
                M_FIN:    q <= M_IDLE;
                default:  q <= q;
            endcase
        end
    end

    function automatic int lat_of(input logic [3:0] b);
        case (b)
            4'b0001: return lat[0];
            4'b0010: return lat[1];
            4'b0100: return lat[2];
            4'b1000: return lat[3];
            default: return 0;
        endcase
    endfunction

    // Stage blocks: done returned lat[i] cycles after the launch; 0 means never.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_done <= 4'b0000;
            resp_wait <= 0;
            resp_bit  <= 4'b0000;
        end else begin
            resp_done <= 4'b0000;
            if (resp_wait > 0) begin
                if (resp_wait == 1) resp_done <= resp_bit;
                resp_wait <= resp_wait - 1;
            end
            if (stage_start != 4'b0000) begin
                resp_bit  <= stage_start;
                resp_wait <= lat_of(stage_start);
            end
        end
    end

    // Event counters and invariant watch.
    always @(negedge clk) begin
        run_cnt <= run_cnt + (run ? 1 : 0);
        if (stage_start != 4'b0000) begin
            ss_cnt <= ss_cnt + 1;
            ss_seq <= {ss_seq[11:0], stage_start};
        end
        if ((run && (stage_start != 4'b0000)) || !$onehot0(stage_start)) bad_cnt <= bad_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        force_done = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ss(input logic [3:0] bits, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (stage_start == bits) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, 32'(found), 1);
    endtask

    task automatic wait_busy_low(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, 32'(found), 1);
    endtask

    task automatic wait_fin(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (fin) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, 32'(found), 1);
    endtask

    initial begin
        // Reset values while rst_n is held low.
        @(negedge clk);
        check("rst_run", 32'(run), 0);
        check("rst_ss", 32'(stage_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_iter", 32'(iter_cnt), 0);
        check("rst_last", 32'(last_cycles), 0);
        check("rst_fin", 32'(fin), 0);
        tick(1);
        rst_n = 1'b1;
        tick(7);

        // Train pass, every stage done 5 cycles after its launch.
        mode = TRAIN;
        lat  = '{5, 5, 5, 5};
        r0   = run_cnt;
        pulse_start();
        check("tr_start_run", 32'(run), 1);
        check("tr_busy_set", 32'(busy), 1);
        tick(1);
        check("tr_first_ss", 32'(stage_start), 32'h1);
        check("tr_first_ss_norun", 32'(run), 0);
        wait_busy_low("tr_wait_end");
        tick(2);
        check("tr_ss_order", 32'(ss_seq), 32'h1248);
        check("tr_run_count", 32'(run_cnt - r0), 6);
        check("tr_q_idle", 32'(q), 32'(M_IDLE));
        check("tr_last", 32'(last_cycles), 6);
        check("tr_iter", 32'(iter_cnt), 1);
        check("tr_busy_end", 32'(busy), 0);
        check("tr_err", 32'(err), 0);

        // Inference pass: S1 done after 3 cycles, then parked on M_FIN.
        do_reset();
        mode = 1'b0;
        lat  = '{3, 5, 5, 5};
        pulse_start();
        wait_fin("inf_wait_fin");
        tick(2);
        check("inf_fin", 32'(fin), 1);
        check("inf_busy", 32'(busy), 0);
        check("inf_q", 32'(q), 32'(M_FIN));
        check("inf_last", 32'(last_cycles), 4);
        r0 = run_cnt;
        tick(100);
        check("inf_no_run", 32'(run_cnt - r0), 0);
        check("inf_err", 32'(err), 0);

        // Done filtering: same-cycle done and wrong-stage done are ignored.
        do_reset();
        mode = TRAIN;
        lat  = '{0, 5, 5, 5};
        pulse_start();
        tick(1);
        check("flt_ss", 32'(stage_start), 32'h1);
        force_done = 4'b0001;
        r0 = run_cnt;
        tick(1);
        force_done = 4'b0000;
        tick(1);
        force_done = 4'b0100;
        tick(1);
        force_done = 4'b0000;
        tick(4);
        check("flt_no_run", 32'(run_cnt - r0), 0);
        check("flt_still_busy", 32'(busy), 1);
        force_done = 4'b0001;
        tick(1);
        force_done = 4'b0000;
        check("flt_done_run", 32'(run), 1);
        check("flt_last", 32'(last_cycles), 8);
        tick(1);
        check("flt_next_ss", 32'(stage_start), 32'h2);
        wait_busy_low("flt_wait_end");
        check("flt_iter", 32'(iter_cnt), 1);

        // Timeout: S2 never completes.
        do_reset();
        lat = '{5, 0, 5, 5};
        pulse_start();
        wait_ss(4'b0010, "to_wait_ss2");
        tick(15);
        check("to_err_early", 32'(err), 0);
        tick(1);
        check("to_err_set", 32'(err), 1);
        r0 = run_cnt;
        s0 = ss_cnt;
        tick(20);
        check("to_no_run", 32'(run_cnt - r0), 0);
        check("to_no_ss", 32'(ss_cnt - s0), 0);
        check("to_err_sticky", 32'(err), 1);

        // Reset in the S3 wait after one completed pass, then restart.
        do_reset();
        lat = '{2, 2, 2, 2};
        pulse_start();
        wait_busy_low("rs_first_pass");
        check("rs_iter_pre", 32'(iter_cnt), 1);
        pulse_start();
        wait_ss(4'b0100, "rs_wait_ss3");
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("rs_run", 32'(run), 0);
        check("rs_ss", 32'(stage_start), 0);
        check("rs_busy", 32'(busy), 0);
        check("rs_err", 32'(err), 0);
        check("rs_iter", 32'(iter_cnt), 0);
        check("rs_last", 32'(last_cycles), 0);
        tick(1);
        rst_n = 1'b1;
        r0 = run_cnt;
        tick(6);
        check("rs_quiet", 32'(run_cnt - r0), 0);
        pulse_start();
        wait_busy_low("rs_second_pass");
        tick(1);
        check("rs_ss_order", 32'(ss_seq), 32'h1248);
        check("rs_iter_post", 32'(iter_cnt), 1);
        check("rs_last_post", 32'(last_cycles), 3);
        check("rs_q_idle", 32'(q), 32'(M_IDLE));

        // Iteration counter wrap with a 2-bit counter.
        do_reset();
        lat = '{1, 1, 1, 1};
        for (int i = 0; i < 4; i++) begin
            pulse_start();
            wait_busy_low("wr_wait_end");
            check("wr_iter", 32'(iter_cnt), 32'(exp_iter[i]));
        end
        check("wr_last", 32'(last_cycles), 2);

        check("invariants", 32'(bad_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
